// File: rtl/mem_dma_pkg.sv
// rtl/mem_dma_pkg.sv - shared types and memory-map constants for the mem_dma bus initiator
package mem_dma_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_A,
    RD_D,
    WR,
    DONE
  } dma_state_t;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_LEN_W  = 13;

  localparam logic [15:0] RAM_BASE    = 16'h0000;
  localparam logic [15:0] ROM_BASE    = 16'hF000;
  localparam int          REGION_SIZE = 4096;

endpackage

// File: rtl/mem_dma.sv
// rtl/mem_dma.sv - second bus master copying a byte block with read/read/write cycles
module mem_dma
  import mem_dma_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int LEN_W  = DEF_LEN_W
) (
  input  logic              ph2,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] src,
  input  logic [ADDR_W-1:0] dst,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] address,
  inout  wire  [7:0]        data,
  output logic              read_write_sel
);

  dma_state_t        state_q;
  logic [ADDR_W-1:0] src_q, dst_q, addr_q;
  logic [LEN_W-1:0]  len_q, i_q;
  logic [7:0]        buf_q;
  logic              rw_q, drv_q, busy_q, done_q;

  logic [LEN_W-1:0]  i_inc_d;
  logic [ADDR_W-1:0] wr_addr_d, rd_next_d;

  assign i_inc_d   = i_q + LEN_W'(1);
  assign wr_addr_d = dst_q + ADDR_W'(i_q);
  assign rd_next_d = src_q + ADDR_W'(i_inc_d);

  // Drive enable is registered alongside rw_q so the bus never sees both masters at once.
  assign data           = drv_q ? buf_q : 8'bz;
  assign address        = addr_q;
  assign read_write_sel = rw_q;
  assign busy           = busy_q;
  assign done           = done_q;

  always_ff @(posedge ph2 or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      i_q     <= '0;
      buf_q   <= '0;
      addr_q  <= '0;
      rw_q    <= 1'b1;
      drv_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            busy_q <= 1'b1;
            if (len == '0) begin
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              src_q   <= src;
              dst_q   <= dst;
              len_q   <= len;
              i_q     <= '0;
              addr_q  <= src;
              state_q <= RD_A;
            end
          end
        end
        RD_A: state_q <= RD_D;
        RD_D: begin
          buf_q   <= data;
          addr_q  <= wr_addr_d;
          rw_q    <= 1'b0;
          drv_q   <= 1'b1;
          state_q <= WR;
        end
        WR: begin
          i_q   <= i_inc_d;
          rw_q  <= 1'b1;
          drv_q <= 1'b0;
          if (i_inc_d == len_q) begin
            addr_q  <= '0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            addr_q  <= rd_next_d;
            state_q <= RD_A;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_dma.sv
// tb/tb_mem_dma.sv - self-checking bench for mem_dma with a behavioural bus responder and copy model
module tb_mem_dma;

  logic        ph2 = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] src = '0, dst = '0;
  logic [12:0] len = '0;
  logic        busy, done, read_write_sel;
  logic [15:0] address;
  wire  [7:0]  data;

  int checks = 0;
  int failures = 0;

  mem_dma dut (
    .ph2(ph2), .reset(reset), .start(start), .src(src), .dst(dst), .len(len),
    .busy(busy), .done(done), .address(address), .data(data),
    .read_write_sel(read_write_sel)
  );

  always #5 ph2 = ~ph2;

  logic [7:0]  mem     [65536];
  logic [7:0]  exp_mem [65536];
  logic [7:0]  rd_q = '0;
  logic        ovr_en = 1'b0;
  logic [7:0]  ovr_val = '0;
  logic [16:0] bus_log [$];
  int          done_cnt = 0;

  function automatic bit mapped(input logic [15:0] a);
    return (a < 16'h1000) || (a >= 16'hF000);
  endfunction

  function automatic logic [7:0] bus_rd(input logic [15:0] a);
    return mapped(a) ? mem[a] : 8'h00;
  endfunction

  function automatic logic [7:0] model_rd(input logic [15:0] a);
    return mapped(a) ? exp_mem[a] : 8'h00;
  endfunction

  // Responder: latch on posedge while reading, write RAM on negedge while writing.
  always @(posedge ph2) if (read_write_sel) rd_q <= bus_rd(address);
  assign data = read_write_sel ? (ovr_en ? ovr_val : rd_q) : 8'bz;

  always @(negedge ph2) begin
    if (!read_write_sel && address < 16'h1000) mem[address] = data;
    if (busy && !done) bus_log.push_back({read_write_sel, address});
    if (done) done_cnt++;
  end

  task automatic chk(input bit ok, input string name, input int act, input int exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_copy(input logic [15:0] s, input logic [15:0] d, input int n);
    logic [15:0] sa, da;
    for (int k = 0; k < n; k++) begin
      sa = s + 16'(k);
      da = d + 16'(k);
      if (da < 16'h1000) exp_mem[da] = model_rd(sa);
    end
  endtask

  task automatic cmp_mem(input string name);
    int bad = 0;
    int first = 0;
    for (int a = 0; a < 65536; a++) begin
      if (mem[a] != exp_mem[a]) begin
        if (bad == 0) first = a;
        bad++;
      end
    end
    chk(bad == 0, {name, " memory (first bad addr in got)"}, first, 0);
  endtask

  task automatic run_xfer(input string name, input logic [15:0] s, input logic [15:0] d,
                          input logic [12:0] n, input bit mid, input int exp_cyc);
    int cyc;
    int dc0;
    int bad;
    logic [16:0] expq [$];
    @(negedge ph2);
    src = s; dst = d; len = n; start = 1'b1;
    @(posedge ph2); #1;
    start = 1'b0;
    bus_log.delete();
    dc0 = done_cnt;
    chk(busy == 1'b1, {name, " busy after start"}, int'(busy), 1);
    cyc = 0;
    while (!done && cyc < 200) begin
      @(posedge ph2); #1;
      cyc++;
      if (mid && cyc == 4) begin
        start = 1'b1; src = 16'h0000; dst = 16'h0600; len = 13'd8;
      end
      if (mid && cyc == 7) start = 1'b0;
    end
    chk(done && cyc == exp_cyc, {name, " done latency"}, cyc, exp_cyc);
    chk(busy == 1'b1, {name, " busy in done"}, int'(busy), 1);
    @(posedge ph2); #1;
    chk(!done && !busy, {name, " busy/done fall"}, int'({busy, done}), 0);
    chk(done_cnt - dc0 == 1, {name, " done pulses"}, done_cnt - dc0, 1);
    for (int k = 0; k < int'(n); k++) begin
      expq.push_back({1'b1, s + 16'(k)});
      expq.push_back({1'b1, s + 16'(k)});
      expq.push_back({1'b0, d + 16'(k)});
    end
    bad = (bus_log.size() == expq.size()) ? 0 : 1;
    if (bad == 0)
      foreach (expq[k]) if (bus_log[k] != expq[k]) bad++;
    chk(bad == 0, {name, " bus access sequence (log size)"}, bus_log.size(), expq.size());
    model_copy(s, d, int'(n));
    cmp_mem(name);
  endtask

  typedef struct {
    logic [15:0] s;
    logic [15:0] d;
    logic [12:0] n;
    bit          mid;
    int          cyc;
    logic [15:0] a0;
    logic [7:0]  e0;
    logic [15:0] a1;
    logic [7:0]  e1;
  } vec_t;

  vec_t tbl [5];

  initial begin
    int nw, cyc, kind;
    logic [15:0] s, d;
    logic [12:0] n;

    for (int a = 0; a < 65536; a++) mem[a] = mapped(16'(a)) ? 8'($urandom) : 8'h00;
    mem[16'hF000] = 8'hA9; mem[16'hF001] = 8'h01; mem[16'hF002] = 8'h8D; mem[16'hF003] = 8'h00;
    mem[16'hFFFF] = 8'h77; mem[16'h0000] = 8'h33; mem[16'h0010] = 8'hEE;
    mem[16'h0400] = 8'h5C; mem[16'h0302] = 8'hC3;
    for (int a = 0; a < 65536; a++) exp_mem[a] = mem[a];

    tbl[0] = '{16'hF000, 16'h0100, 13'd4, 1'b0, 12, 16'h0101, 8'h01, 16'h0103, 8'h00};
    tbl[1] = '{16'hF000, 16'h0400, 13'd0, 1'b0, 0,  16'h0400, 8'h5C, 16'h0400, 8'h5C};
    tbl[2] = '{16'hFFFF, 16'h0200, 13'd2, 1'b0, 6,  16'h0200, 8'h77, 16'h0201, 8'h33};
    tbl[3] = '{16'h2000, 16'h0010, 13'd1, 1'b0, 3,  16'h0010, 8'h00, 16'h0010, 8'h00};
    tbl[4] = '{16'hF000, 16'h0500, 13'd4, 1'b1, 12, 16'h0500, 8'hA9, 16'h0502, 8'h8D};

    #12;
    chk(!busy && !done, "reset busy/done", int'({busy, done}), 0);
    chk(read_write_sel == 1'b1, "reset rw", int'(read_write_sel), 1);
    chk(address == 16'h0000, "reset address", int'(address), 0);
    @(negedge ph2);
    reset = 1'b0;

    for (int t = 0; t < 5; t++) begin
      run_xfer($sformatf("vec%0d", t), tbl[t].s, tbl[t].d, tbl[t].n, tbl[t].mid, tbl[t].cyc);
      chk(mem[tbl[t].a0] == tbl[t].e0, $sformatf("vec%0d byte a0", t), int'(mem[tbl[t].a0]), int'(tbl[t].e0));
      chk(mem[tbl[t].a1] == tbl[t].e1, $sformatf("vec%0d byte a1", t), int'(mem[tbl[t].a1]), int'(tbl[t].e1));
    end

    // Abort during the third write cycle, before the responder's negedge write.
    @(negedge ph2);
    src = 16'hF000; dst = 16'h0300; len = 13'd4; start = 1'b1;
    @(posedge ph2); #1;
    start = 1'b0;
    nw = 0; cyc = 0;
    while (nw < 3 && cyc < 100) begin
      @(posedge ph2); #1;
      cyc++;
      if (!read_write_sel) nw++;
    end
    chk(nw == 3, "reset reach third write", nw, 3);
    ovr_val = 8'h5A; ovr_en = 1'b1; reset = 1'b1;
    #1;
    chk(read_write_sel == 1'b1, "abort rw", int'(read_write_sel), 1);
    chk(data == 8'h5A, "abort data released", int'(data), 8'h5A);
    chk(!busy && !done && address == 16'h0000, "abort outputs", int'({busy, done, address}), 0);
    @(negedge ph2); @(negedge ph2);
    reset = 1'b0; ovr_en = 1'b0;
    chk(mem[16'h0302] == 8'hC3, "abort byte2 untouched", int'(mem[16'h0302]), 8'hC3);
    chk(mem[16'h0301] == 8'h01, "abort byte1 written", int'(mem[16'h0301]), 8'h01);
    model_copy(16'hF000, 16'h0300, 2);
    cmp_mem("abort");
    chk(busy == 1'b0, "post reset busy", int'(busy), 0);
    run_xfer("post reset", 16'hF000, 16'h0700, 13'd4, 1'b0, 12);

    for (int t = 0; t < 10; t++) begin
      kind = int'($urandom_range(0, 3));
      d = 16'($urandom_range(0, 16'h0FFF));
      n = 13'($urandom_range(0, 24));
      case (kind)
        0: s = 16'hF000 + 16'($urandom_range(0, 4095));
        1: begin
          s = 16'($urandom_range(0, 16'h0FE0));
          d = s + 16'($urandom_range(1, 3));
        end
        2: s = 16'h1000 + 16'($urandom_range(0, 16'hDFFF));
        default: s = 16'hFFF0 + 16'($urandom_range(0, 15));
      endcase
      run_xfer($sformatf("rand%0d", t), s, d, n, 1'b0, 3 * int'(n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_dma.md
# mem_dma

Bus-initiator block copying a block of bytes from one address range to another over the shared 8-bit memory bus: the same address/data/read_write_sel interface the `mem` responder serves. It sits beside the CPU as a second bus master (bus arbitration is outside this block) for program loading (ROM at 0xF000–0xFFFF to RAM at 0x0000–0x0FFF) and memory bring-up tests. A transfer is a start/busy/done handshake. Each byte costs one read access and one write access, issued with the responder's ph2-edge timing.

## Interface
- `ADDR_W`, 16: bus address width.
- `LEN_W`, 13: length width; maximum length is 4096.
- `ph2`  in  1  sole clock; all state updates on posedge.
- `reset`  in  1  asynchronous, active-high.
- `start`  in  1  request a transfer; sampled on posedge ph2 only in IDLE.
- `src`  in  16  source start address, latched on accepted start.
- `dst`  in  16  destination start address, latched on accepted start.
- `len`  in  13  byte count, latched on accepted start; 0 is legal.
- `busy`  out  1  high from the cycle after an accepted start through the DONE cycle.
- `done`  out  1  one-cycle pulse when the transfer completes.
- `address`  out  16  bus address.
- `data`  inout  8  bus data; driven only in WR, high-Z otherwise.
- `read_write_sel`  out  1  1 = read, 0 = write.

## Operation
- States: IDLE, RD_A, RD_D, WR, DONE.
- IDLE
  - `address` = 0x0000, `read_write_sel` = 1, `data` = Z, `busy` = 0.
  - `start` with `len` ≠ 0: latch `src`, `dst`, `len`; clear index `i`; go to RD_A.
  - `start` with `len` = 0: go directly to DONE.
- RD_A: `address` = src+i, `read_write_sel` = 1. Go to RD_D.
- RD_D
  - `address` = src+i, `read_write_sel` = 1.
  - On the closing posedge, capture `data` into byte latch `buf`. Go to WR.
- WR
  - `address` = dst+i, `read_write_sel` = 0, `data` driven with `buf`.
  - On the closing posedge: `i` ← i+1. If i+1 = len, go to DONE; else go to RD_A.
- DONE: `done` = 1, `busy` = 1, bus signals as in IDLE. Go to IDLE.
- Address arithmetic is modulo 2^16: 0xFFFF+1 = 0x0000. `i` is `LEN_W` bits.
- Copy direction is always ascending, with no overlap correction. When dst lies inside (src, src+len), the copy is a forward smear. This is intended.
- `start` outside IDLE is ignored. Latched operands are unaffected by input changes mid-transfer.
- Reset, at any time including mid-WR, takes effect immediately:
  - state = IDLE, `read_write_sel` = 1, `data` = Z, `address` = 0, `busy` = 0, `done` = 0, `i` = 0, `buf` = 0.
  - A write aborted before the negedge ph2 of its WR cycle must not occur.

## Timing
- All outputs are registered or decoded from state only. No input-to-output combinational path.
- Read: address is stable for two cycles (RD_A, RD_D). The responder latches read data at the posedge ending RD_A and presents it through RD_D. The initiator samples at the posedge ending RD_D.
- Write: address, data and read_write_sel = 0 are stable from the posedge starting WR. The responder writes at the negedge ph2 inside WR. Data is released at the posedge ending WR.
- Per-byte cost: 3 cycles. Start accepted at posedge T gives `busy` from T+1.
  - `len` = N > 0: `done` at cycle T+1+3N.
  - `len` = 0: `done` at T+1.
- `done` and `busy` fall together at the posedge after DONE. A new `start` is accepted at that same edge or later.

## Structure
- `mem_dma_pkg` holds:
  - the `dma_state_t` enum (IDLE, RD_A, RD_D, WR, DONE);
  - `ADDR_W` and `LEN_W` defaults;
  - map constants `RAM_BASE` = 0x0000, `ROM_BASE` = 0xF000, `REGION_SIZE` = 4096.
- Single module, with no sub-module. The address/index datapath is small enough to sit with the FSM.

## Test plan
- ROM preload 0xF000..0xF003 = A9,01,8D,00; start src=0xF000 dst=0x0100 len=4 → RAM[0x100..0x103] = A9,01,8D,00; `done` at T+13; 8 bus accesses, with read_write_sel=0 only in 4 single cycles.
- len=0 → `done` pulse at T+1; no cycle with read_write_sel=0; RAM unchanged.
- src=0xFFFF dst=0x0200 len=2 → addresses read are 0xFFFF then 0x0000; RAM[0x200] = ROM[0xFFF], RAM[0x201] = RAM[0x000].
- src=0x2000 (unmapped) dst=0x0010 len=1 → RAM[0x010] = 0x00.
- Second `start` with different operands asserted mid-transfer → ignored; only the first copy lands; a single `done`.
- Reset asserted mid-WR of byte 2 of a 4-byte copy (before negedge) → read_write_sel=1 and data=Z immediately; byte 2 destination unchanged, bytes 0–1 written; after release, `busy` = 0 and a new transfer completes normally.
